// File: rtl/rf_csr_pkg.sv
// rf_csr_pkg
//   Shared constants for the writeback architectural-state block. It holds the
//   CSR address map, the mcause codes, the mstatus/mie/mip bit positions, the
//   commit-event encoding and a helper that ranks synchronous exception flags.
//   There are no ports: this package is imported by rf_csr_trap_unit.
package rf_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  localparam logic [31:0] CAUSE_IAM    = 32'd0;
  localparam logic [31:0] CAUSE_BREAK  = 32'd3;
  localparam logic [31:0] CAUSE_LAM    = 32'd4;
  localparam logic [31:0] CAUSE_SAM    = 32'd6;
  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_MTIMER = 32'h8000_0007;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIP_MTIP     = 7;

  localparam logic [1:0] PRIV_M = 2'b11;

  // What a single accepted commit does to the control flow, after priority.
  typedef enum logic [2:0] {
    EV_NONE,
    EV_EXC,
    EV_IRQ,
    EV_MRET,
    EV_FENCEI,
    EV_MISPRED
  } commit_event_e;

  // Several exception flags may be raised together by one instruction; the
  // earliest-detected one wins and ecall is the fallback.
  function automatic logic [31:0] exc_cause(input logic iam, input logic ebreak,
                                            input logic lam, input logic sam);
    if (iam)         return CAUSE_IAM;
    else if (ebreak) return CAUSE_BREAK;
    else if (lam)    return CAUSE_LAM;
    else if (sam)    return CAUSE_SAM;
    else             return CAUSE_ECALL;
  endfunction

endpackage

// File: rtl/rf_csr_counter64.sv
// rf_csr_counter64
//   64-bit counter built from two 32-bit halves that software can overwrite
//   independently; used for both mcycle and minstret.
//   Ports:
//     clock, reset       clock and asynchronous active-high reset
//     inc                add one this cycle
//     wr_lo / wr_hi      replace the low / high half with wdata this cycle
//     wdata              CSR write data
//     count              current 64-bit value
module rf_csr_counter64 (
  input  logic        clock,
  input  logic        reset,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  logic [31:0] lo;
  logic [31:0] hi;
  logic        carry;

  // A write to the low half swallows that cycle's increment, so it must not
  // leak a carry into the high half either.
  assign carry = inc & ~wr_lo & (lo == 32'hFFFF_FFFF);

  // Each half is replaced by a write or advanced otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lo <= '0;
      hi <= '0;
    end else begin
      lo <= wr_lo ? wdata : lo + {31'b0, inc};
      hi <= wr_hi ? wdata : hi + {31'b0, carry};
    end
  end

  assign count = {hi, lo};

endmodule

// File: rtl/rf_csr_trap_unit.sv
// rf_csr_trap_unit
//   Architectural state at writeback. It contains the GPR file with NRD
//   combinational read ports and optional same-cycle write bypass, the M-mode
//   CSRs, the mcycle/minstret counters, the machine timer interrupt, and the
//   prioritised trap/redirect logic that flushes the pipeline and reloads the PC.
//   Ports:
//     clock, reset                      clock and asynchronous active-high reset
//     rs_addr / rs_data                 packed GPR read addresses / data
//     commit_valid, commit_pc, commit_npc   retiring instruction and its next PC
//     rd_wen, rd, rd_wdata              GPR write of the retiring instruction
//     csr_raddr / csr_rdata             combinational CSR read
//     csr_wen, csr_waddr, csr_wdata     CSR write of the retiring instruction
//     exc_*                             synchronous exception flags
//     mret, fence_i, mispredict         control events of the retiring instruction
//     irq_timer                         level machine-timer interrupt request
//     redirect_valid/_pc, flush_icache  registered one-cycle redirect to the IFU
module rf_csr_trap_unit #(
  parameter int          XLEN      = 32,
  parameter int          NREG      = 16,
  parameter int          NRD       = 2,
  parameter int          BYPASS    = 1,
  parameter logic [31:0] MVENDORID = 32'h7973_7978,
  parameter logic [31:0] MARCHID   = 32'h017D_9F58
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NRD*5-1:0]    rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  input  logic                commit_valid,
  input  logic [XLEN-1:0]     commit_pc,
  input  logic [XLEN-1:0]     commit_npc,
  input  logic                rd_wen,
  input  logic [4:0]          rd,
  input  logic [XLEN-1:0]     rd_wdata,
  input  logic [11:0]         csr_raddr,
  output logic [XLEN-1:0]     csr_rdata,
  input  logic                csr_wen,
  input  logic [11:0]         csr_waddr,
  input  logic [XLEN-1:0]     csr_wdata,
  input  logic                exc_iam,
  input  logic                exc_ecall,
  input  logic                exc_ebreak,
  input  logic                exc_lam,
  input  logic                exc_sam,
  input  logic                mret,
  input  logic                fence_i,
  input  logic                mispredict,
  input  logic                irq_timer,
  output logic                redirect_valid,
  output logic [XLEN-1:0]     redirect_pc,
  output logic                flush_icache
);

  import rf_csr_pkg::*;

  localparam int AW = $clog2(NREG);

  if (XLEN != 32) begin : g_xlen_check
    $error("rf_csr_trap_unit supports only XLEN == 32");
  end

  logic [XLEN-1:0] gpr [NREG];

  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic            mie_mtie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [63:0]     mcycle;
  logic [63:0]     minstret;

  logic            commit_ok;
  logic            exc_any;
  logic            irq_pending;
  logic            retire_ok;
  logic            gpr_we;
  logic            csr_we;
  commit_event_e   ev;
  logic [XLEN-1:0] mstatus_word;

  // Only the low AW bits of the register addresses select a GPR; this
  // reduction keeps the remaining bits referenced.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd, rs_addr};

  // The cycle showing redirect_valid is the shadow of a redirect: whatever
  // commits then is on the wrong path and is dropped without side effects.
  assign commit_ok   = commit_valid & ~redirect_valid;
  assign exc_any     = exc_iam | exc_ecall | exc_ebreak | exc_lam | exc_sam;
  assign irq_pending = mstatus_mie & mie_mtie & irq_timer;

  // An interrupt lets the instruction complete; only exceptions cancel it.
  assign retire_ok = commit_ok & ~exc_any;
  assign gpr_we    = retire_ok & rd_wen & (rd[AW-1:0] != '0);
  assign csr_we    = retire_ok & csr_wen;

  // Rank the control-flow effects of the accepted commit.
  always_comb begin
    ev = EV_NONE;
    if (commit_ok) begin
      if (exc_any)          ev = EV_EXC;
      else if (irq_pending) ev = EV_IRQ;
      else if (mret)        ev = EV_MRET;
      else if (fence_i)     ev = EV_FENCEI;
      else if (mispredict)  ev = EV_MISPRED;
    end
  end

  // Read ports, with x0 hard-wired and optional forwarding of the write.
  always_comb begin
    logic [AW-1:0] idx;
    rs_data = '0;
    for (int k = 0; k < NRD; k++) begin
      idx = rs_addr[5*k +: AW];
      if (idx == '0)
        rs_data[k*XLEN +: XLEN] = '0;
      else if ((BYPASS != 0) && gpr_we && (rd[AW-1:0] == idx))
        rs_data[k*XLEN +: XLEN] = rd_wdata;
      else
        rs_data[k*XLEN +: XLEN] = gpr[idx];
    end
  end

  // GPR array write port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else if (gpr_we) begin
      gpr[rd[AW-1:0]] <= rd_wdata;
    end
  end

  // CSR writes first, then trap entry / mret; the later assignments win, so
  // trap side effects override a same-cycle software write. All reads on the
  // right-hand side see the values from before this edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_mtie     <= 1'b0;
      mtvec        <= '0;
      mscratch     <= '0;
      mepc         <= '0;
      mcause       <= '0;
    end else begin
      if (csr_we) begin
        case (csr_waddr)
          CSR_MSTATUS: begin
            mstatus_mie  <= csr_wdata[MSTATUS_MIE];
            mstatus_mpie <= csr_wdata[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_mtie <= csr_wdata[MIE_MTIE];
          CSR_MTVEC:    mtvec    <= {csr_wdata[XLEN-1:2], 2'b00};
          CSR_MSCRATCH: mscratch <= csr_wdata;
          CSR_MEPC:     mepc     <= {csr_wdata[XLEN-1:2], 2'b00};
          CSR_MCAUSE:   mcause   <= csr_wdata;
          default: ;
        endcase
      end
      case (ev)
        EV_EXC: begin
          mepc         <= commit_pc;
          mcause       <= exc_cause(exc_iam, exc_ebreak, exc_lam, exc_sam);
          mstatus_mpie <= mstatus_mie;
          mstatus_mie  <= 1'b0;
        end
        EV_IRQ: begin
          mepc         <= commit_npc;
          mcause       <= CAUSE_MTIMER;
          mstatus_mpie <= mstatus_mie;
          mstatus_mie  <= 1'b0;
        end
        EV_MRET: begin
          mstatus_mie  <= mstatus_mpie;
          mstatus_mpie <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  rf_csr_counter64 u_mcycle (
    .clock (clock),
    .reset (reset),
    .inc   (1'b1),
    .wr_lo (csr_we && (csr_waddr == CSR_MCYCLE)),
    .wr_hi (csr_we && (csr_waddr == CSR_MCYCLEH)),
    .wdata (csr_wdata),
    .count (mcycle)
  );

  rf_csr_counter64 u_minstret (
    .clock (clock),
    .reset (reset),
    .inc   (retire_ok),
    .wr_lo (csr_we && (csr_waddr == CSR_MINSTRET)),
    .wr_hi (csr_we && (csr_waddr == CSR_MINSTRETH)),
    .wdata (csr_wdata),
    .count (minstret)
  );

  // MPP is fixed at M-mode since this core has no lower privilege levels.
  assign mstatus_word = {19'b0, PRIV_M, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};

  // Combinational CSR read mux; unmapped addresses read as zero.
  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      CSR_MSTATUS:   csr_rdata = mstatus_word;
      CSR_MIE:       csr_rdata = {24'b0, mie_mtie, 7'b0};
      CSR_MTVEC:     csr_rdata = mtvec;
      CSR_MSCRATCH:  csr_rdata = mscratch;
      CSR_MEPC:      csr_rdata = mepc;
      CSR_MCAUSE:    csr_rdata = mcause;
      CSR_MIP:       csr_rdata = {24'b0, irq_timer, 7'b0};
      CSR_MCYCLE:    csr_rdata = mcycle[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
      CSR_MINSTRET:  csr_rdata = minstret[31:0];
      CSR_MINSTRETH: csr_rdata = minstret[63:32];
      CSR_MVENDORID: csr_rdata = MVENDORID;
      CSR_MARCHID:   csr_rdata = MARCHID;
      default:       csr_rdata = '0;
    endcase
  end

  // Redirect register: a one-cycle pulse because the shadow cycle that
  // follows can never raise a new event. The target holds between pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_icache   <= 1'b0;
    end else begin
      redirect_valid <= (ev != EV_NONE);
      flush_icache   <= (ev == EV_FENCEI);
      case (ev)
        EV_EXC, EV_IRQ:        redirect_pc <= mtvec;
        EV_MRET:               redirect_pc <= mepc;
        EV_FENCEI, EV_MISPRED: redirect_pc <= commit_npc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_csr_trap_unit.sv
// tb_rf_csr_trap_unit
//   Self-checking bench for rf_csr_trap_unit: directed scenarios followed by
//   randomized commits, all compared against an architectural reference model.
module tb_rf_csr_trap_unit;

  localparam int XLEN = 32;
  localparam int NRD  = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic [9:0]      rs_addr;
  logic [63:0]     rs_data;
  logic            commit_valid;
  logic [31:0]     commit_pc, commit_npc;
  logic            rd_wen;
  logic [4:0]      rd;
  logic [31:0]     rd_wdata;
  logic [11:0]     csr_raddr;
  logic [31:0]     csr_rdata;
  logic            csr_wen;
  logic [11:0]     csr_waddr;
  logic [31:0]     csr_wdata;
  logic            exc_iam, exc_ecall, exc_ebreak, exc_lam, exc_sam;
  logic            mret, fence_i, mispredict, irq_timer;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic            flush_icache;

  always #5 clock = ~clock;

  rf_csr_trap_unit #(
    .XLEN(XLEN), .NREG(16), .NRD(NRD), .BYPASS(1),
    .MVENDORID(32'h7973_7978), .MARCHID(32'h017D_9F58)
  ) dut (
    .clock(clock), .reset(reset), .rs_addr(rs_addr), .rs_data(rs_data),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_npc(commit_npc),
    .rd_wen(rd_wen), .rd(rd), .rd_wdata(rd_wdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .exc_iam(exc_iam), .exc_ecall(exc_ecall), .exc_ebreak(exc_ebreak),
    .exc_lam(exc_lam), .exc_sam(exc_sam),
    .mret(mret), .fence_i(fence_i), .mispredict(mispredict), .irq_timer(irq_timer),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush_icache(flush_icache)
  );

  typedef struct {
    logic        cv;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        rd_wen;
    logic [4:0]  rd;
    logic [31:0] rd_wdata;
    logic [9:0]  rs;
    logic [11:0] craddr;
    logic        csr_wen;
    logic [11:0] cwaddr;
    logic [31:0] cwdata;
    logic        iam, ecall, ebreak, lam, sam;
    logic        mret, fence, misp, irq;
  } stim_t;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [31:0] obs_rs0, obs_rs1, obs_csr;

  // Reference model: architectural state only.
  logic [31:0] m_gpr [16];
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_mcycle, m_minstret;
  bit          m_rv, m_flush;
  logic [31:0] m_rpc;

  logic [11:0] csr_list [13] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11, 12'hF12};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic logic [63:0] counterNext(input logic [63:0] c, input bit inc,
                                              input bit wlo, input bit whi, input logic [31:0] d);
    logic [63:0] n;
    n = c + 64'(inc);
    if (wlo) n = {c[63:32], d};
    if (whi) n = {d, n[31:0]};
    return n;
  endfunction

  function automatic logic [31:0] modelCsr(input logic [11:0] a, input logic irq);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return irq ? 32'h80 : 32'h0;
      12'hB00: return m_mcycle[31:0];
      12'hB80: return m_mcycle[63:32];
      12'hB02: return m_minstret[31:0];
      12'hB82: return m_minstret[63:32];
      12'hF11: return 32'h7973_7978;
      12'hF12: return 32'h017D_9F58;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit excAny(input stim_t s);
    return s.iam || s.ecall || s.ebreak || s.lam || s.sam;
  endfunction

  function automatic logic [31:0] modelGpr(input stim_t s, input int port);
    logic [4:0] a;
    int idx;
    a   = (port == 0) ? s.rs[4:0] : s.rs[9:5];
    idx = int'(a) % 16;
    if (idx == 0) return 32'h0;
    if (s.cv && !m_rv && !excAny(s) && s.rd_wen && (int'(s.rd) % 16 == idx)) return s.rd_wdata;
    return m_gpr[idx];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) m_gpr[i] = 32'h0;
    m_mstatus = 32'h1800; m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    m_mcycle = 0; m_minstret = 0; m_rv = 0; m_flush = 0; m_rpc = 0;
  endtask

  task automatic modelStep(input stim_t s);
    bit          acc, exc, irqt, retire, w;
    logic [31:0] old_ms, old_mepc, old_mtvec, cause;
    acc       = s.cv && !m_rv;
    exc       = excAny(s);
    irqt      = m_mstatus[3] && m_mie[7] && s.irq;
    retire    = acc && !exc;
    w         = retire && s.csr_wen;
    old_ms    = m_mstatus;
    old_mepc  = m_mepc;
    old_mtvec = m_mtvec;
    if (retire && s.rd_wen && (int'(s.rd) % 16 != 0)) m_gpr[int'(s.rd) % 16] = s.rd_wdata;
    if (w) begin
      case (s.cwaddr)
        12'h300: m_mstatus  = 32'h1800 | (s.cwdata & 32'h88);
        12'h304: m_mie      = s.cwdata & 32'h80;
        12'h305: m_mtvec    = s.cwdata & ~32'h3;
        12'h340: m_mscratch = s.cwdata;
        12'h341: m_mepc     = s.cwdata & ~32'h3;
        12'h342: m_mcause   = s.cwdata;
        default: ;
      endcase
    end
    m_mcycle   = counterNext(m_mcycle, 1'b1, w && s.cwaddr == 12'hB00, w && s.cwaddr == 12'hB80, s.cwdata);
    m_minstret = counterNext(m_minstret, retire, w && s.cwaddr == 12'hB02, w && s.cwaddr == 12'hB82, s.cwdata);
    m_rv = 0; m_flush = 0;
    if (acc && exc) begin
      if (s.iam) cause = 0; else if (s.ebreak) cause = 3; else if (s.lam) cause = 4;
      else if (s.sam) cause = 6; else cause = 11;
      m_mepc = s.pc; m_mcause = cause;
      m_mstatus = 32'h1800 | (old_ms[3] ? 32'h80 : 32'h0);
      m_rv = 1; m_rpc = old_mtvec;
    end else if (acc && irqt) begin
      m_mepc = s.npc; m_mcause = 32'h8000_0007;
      m_mstatus = 32'h1800 | (old_ms[3] ? 32'h80 : 32'h0);
      m_rv = 1; m_rpc = old_mtvec;
    end else if (acc && s.mret) begin
      m_mstatus = 32'h1880 | (old_ms[7] ? 32'h8 : 32'h0);
      m_rv = 1; m_rpc = old_mepc;
    end else if (acc && s.fence) begin
      m_rv = 1; m_flush = 1; m_rpc = s.npc;
    end else if (acc && s.misp) begin
      m_rv = 1; m_rpc = s.npc;
    end
  endtask

  task automatic driveInputs(input stim_t s);
    commit_valid = s.cv; commit_pc = s.pc; commit_npc = s.npc;
    rd_wen = s.rd_wen; rd = s.rd; rd_wdata = s.rd_wdata; rs_addr = s.rs;
    csr_raddr = s.craddr; csr_wen = s.csr_wen; csr_waddr = s.cwaddr; csr_wdata = s.cwdata;
    exc_iam = s.iam; exc_ecall = s.ecall; exc_ebreak = s.ebreak; exc_lam = s.lam; exc_sam = s.sam;
    mret = s.mret; fence_i = s.fence; mispredict = s.misp; irq_timer = s.irq;
  endtask

  // One clock cycle: drive, check combinational reads before the edge, advance
  // the model, then check the registered redirect outputs after the edge.
  task automatic applyStimulus(input stim_t s);
    driveInputs(s);
    #2;
    obs_rs0 = rs_data[31:0];
    obs_rs1 = rs_data[63:32];
    obs_csr = csr_rdata;
    checkOutput("rs_data0", obs_rs0, modelGpr(s, 0));
    checkOutput("rs_data1", obs_rs1, modelGpr(s, 1));
    checkOutput($sformatf("csr_%h", s.craddr), obs_csr, modelCsr(s.craddr, s.irq));
    modelStep(s);
    @(posedge clock);
    #1;
    checkOutput("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_rv});
    checkOutput("redirect_pc", redirect_pc, m_rpc);
    checkOutput("flush_icache", {31'b0, flush_icache}, {31'b0, m_flush});
  endtask

  task automatic doReset();
    reset = 1'b1;
    driveInputs(idleStim());
    #1;
    checkOutput("reset_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    checkOutput("reset_redirect_pc", redirect_pc, 32'h0);
    checkOutput("reset_flush_icache", {31'b0, flush_icache}, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    modelReset();
  endtask

  function automatic logic [11:0] pickCsr();
    if ($urandom_range(0, 7) == 0) return 12'($urandom);
    return csr_list[$urandom_range(0, 12)];
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.cv       = ($urandom_range(0, 3) != 0);
    s.pc       = $urandom;
    s.npc      = $urandom;
    s.rd_wen   = 1'($urandom_range(0, 1));
    s.rd       = 5'($urandom_range(0, 31));
    s.rd_wdata = $urandom;
    s.rs       = 10'($urandom);
    if ($urandom_range(0, 3) == 0) s.rs[4:0] = s.rd;
    s.craddr   = pickCsr();
    s.csr_wen  = ($urandom_range(0, 3) == 0);
    s.cwaddr   = pickCsr();
    s.cwdata   = $urandom;
    s.iam      = ($urandom_range(0, 23) == 0);
    s.ecall    = ($urandom_range(0, 15) == 0);
    s.ebreak   = ($urandom_range(0, 23) == 0);
    s.lam      = ($urandom_range(0, 23) == 0);
    s.sam      = ($urandom_range(0, 23) == 0);
    s.mret     = ($urandom_range(0, 11) == 0);
    s.fence    = ($urandom_range(0, 11) == 0);
    s.misp     = ($urandom_range(0, 7) == 0);
    s.irq      = ($urandom_range(0, 2) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    doReset();

    // Reset state and x5 write/read, x0 stays zero.
    s = idleStim(); s.craddr = 12'h300; applyStimulus(s);
    checkOutput("t1_mstatus_reset", obs_csr, 32'h1800);
    s = idleStim(); s.cv = 1; s.rd_wen = 1; s.rd = 5; s.rd_wdata = 32'hDEAD_BEEF; applyStimulus(s);
    s = idleStim(); s.rs = {5'd5, 5'd5}; applyStimulus(s);
    checkOutput("t1_x5_port0", obs_rs0, 32'hDEAD_BEEF);
    checkOutput("t1_x5_port1", obs_rs1, 32'hDEAD_BEEF);
    s = idleStim(); s.cv = 1; s.rd_wen = 1; s.rd = 0; s.rd_wdata = 32'h1; applyStimulus(s);
    s = idleStim(); s.rs = 10'd0; applyStimulus(s);
    checkOutput("t1_x0", obs_rs0, 32'h0);

    // Same-cycle bypass.
    s = idleStim(); s.cv = 1; s.rd_wen = 1; s.rd = 7; s.rd_wdata = 32'h1234; s.rs = {5'd0, 5'd7};
    applyStimulus(s);
    checkOutput("t2_bypass", obs_rs0, 32'h1234);

    // mcycle low-half wrap carries into mcycleh.
    s = idleStim(); s.craddr = 12'hB80; applyStimulus(s);
    checkOutput("t5_mcycleh_before", obs_csr, 32'h0);
    s = idleStim(); s.cv = 1; s.csr_wen = 1; s.cwaddr = 12'hB00; s.cwdata = 32'hFFFF_FFFE; applyStimulus(s);
    s = idleStim(); s.craddr = 12'hB00; applyStimulus(s);
    checkOutput("t5_mcycle_written", obs_csr, 32'hFFFF_FFFE);
    applyStimulus(s);
    applyStimulus(s);
    checkOutput("t5_mcycle_wrapped", obs_csr, 32'h0);
    s.craddr = 12'hB80; applyStimulus(s);
    checkOutput("t5_mcycleh_carry", obs_csr, 32'h1);

    // ecall trap entry and shadow-cycle discard.
    s = idleStim(); s.cv = 1; s.csr_wen = 1; s.cwaddr = 12'h300; s.cwdata = 32'h8; applyStimulus(s);
    s = idleStim(); s.cv = 1; s.csr_wen = 1; s.cwaddr = 12'h305; s.cwdata = 32'h8000_0103; applyStimulus(s);
    s = idleStim(); s.cv = 1; s.pc = 32'h100; s.ecall = 1; s.rd_wen = 1; s.rd = 9; s.rd_wdata = 32'h55;
    applyStimulus(s);
    checkOutput("t3_redirect_valid", {31'b0, redirect_valid}, 32'h1);
    checkOutput("t3_redirect_pc", redirect_pc, 32'h8000_0100);
    s = idleStim(); s.cv = 1; s.rd_wen = 1; s.rd = 10; s.rd_wdata = 32'h77; applyStimulus(s);
    checkOutput("t3_shadow_redirect_off", {31'b0, redirect_valid}, 32'h0);
    s = idleStim(); s.craddr = 12'h341; s.rs = {5'd9, 5'd10}; applyStimulus(s);
    checkOutput("t3_mepc", obs_csr, 32'h100);
    checkOutput("t3_x10_shadow", obs_rs0, 32'h0);
    checkOutput("t3_x9_suppressed", obs_rs1, 32'h0);
    s.craddr = 12'h342; applyStimulus(s);
    checkOutput("t3_mcause", obs_csr, 32'd11);
    s.craddr = 12'h300; applyStimulus(s);
    checkOutput("t3_mstatus", obs_csr, 32'h1880);

    // Timer interrupt, then mret.
    s = idleStim(); s.cv = 1; s.csr_wen = 1; s.cwaddr = 12'h300; s.cwdata = 32'h8; applyStimulus(s);
    s = idleStim(); s.cv = 1; s.csr_wen = 1; s.cwaddr = 12'h304; s.cwdata = 32'h80; applyStimulus(s);
    s = idleStim(); s.cv = 1; s.npc = 32'h204; s.rd_wen = 1; s.rd = 3; s.rd_wdata = 32'hAB; s.irq = 1;
    applyStimulus(s);
    checkOutput("t4_irq_redirect_pc", redirect_pc, 32'h8000_0100);
    s = idleStim(); applyStimulus(s);
    s = idleStim(); s.craddr = 12'h341; s.rs = {5'd0, 5'd3}; applyStimulus(s);
    checkOutput("t4_mepc", obs_csr, 32'h204);
    checkOutput("t4_x3_written", obs_rs0, 32'hAB);
    s.craddr = 12'h342; applyStimulus(s);
    checkOutput("t4_mcause", obs_csr, 32'h8000_0007);
    s = idleStim(); s.cv = 1; s.mret = 1; applyStimulus(s);
    checkOutput("t4_mret_redirect_pc", redirect_pc, 32'h204);
    s = idleStim(); applyStimulus(s);
    s = idleStim(); s.craddr = 12'h300; applyStimulus(s);
    checkOutput("t4_mstatus_after_mret", obs_csr, 32'h1888);

    // Exception beats fence_i and mispredict; reset kills a live redirect.
    s = idleStim(); s.cv = 1; s.pc = 32'h300; s.npc = 32'h304; s.ecall = 1; s.fence = 1; s.misp = 1;
    applyStimulus(s);
    checkOutput("t6_trap_pc", redirect_pc, 32'h8000_0100);
    checkOutput("t6_no_flush", {31'b0, flush_icache}, 32'h0);
    s = idleStim(); applyStimulus(s);
    s = idleStim(); s.cv = 1; s.npc = 32'h444; s.misp = 1; applyStimulus(s);
    checkOutput("t6_misp_valid", {31'b0, redirect_valid}, 32'h1);
    doReset();

    // Randomized commits against the model.
    for (int n = 0; n < 600; n++) applyStimulus(randStim());

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
